// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 constants, FSM encoding and size/alignment helpers for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_t;

    // Byte count of an access; 0 marks an encoding with no defined size.
    function automatic logic [2:0] lsu_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// rtl/load_extender.sv - sign/zero extension of raw load data according to funct3
module load_extender
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = 32'd0;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'd0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'd0, raw[15:0]};
            F3_W:    ext = raw;
            default: ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with misaligned access splitting
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES        = 4096,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic        split_q;
    logic [2:0]  n_q;
    logic [1:0]  k_q;
    logic [31:0] buf_q;

    logic [2:0]  req_size;
    logic        req_illegal;
    logic        req_range;
    logic        req_mis;
    logic        req_fault;
    logic        req_split;

    assign req_size    = lsu_size(req_funct3);
    assign req_illegal = (req_size == 3'd0) || (req_write && req_funct3[2]);
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign req_range   = ({1'b0, req_addr} + {30'd0, req_size}) > 33'(MEM_BYTES);
    assign req_mis     = lsu_misaligned(req_funct3, req_addr[1:0]);
    assign req_fault   = req_illegal || req_range || (req_mis && !SPLIT_MISALIGNED);
    assign req_split   = req_mis && SPLIT_MISALIGNED;

    assign req_ready = (state == ST_IDLE);

    // Next memory access: byte 0 of a fresh request, or byte k+1 of the latched one.
    logic        from_req;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [2:0]  a_funct3;
    logic        a_write;
    logic        a_split;
    logic [1:0]  idx;
    logic [31:0] wshift;
    logic [31:0] nx_addr;
    logic [31:0] nx_wdata;
    logic [2:0]  nx_funct3;

    always_comb begin
        from_req  = (state == ST_IDLE);
        a_addr    = from_req ? req_addr   : addr_q;
        a_wdata   = from_req ? req_wdata  : wdata_q;
        a_funct3  = from_req ? req_funct3 : funct3_q;
        a_write   = from_req ? req_write  : write_q;
        a_split   = from_req ? req_split  : split_q;
        idx       = from_req ? 2'd0 : k_q + 2'd1;
        wshift    = a_wdata >> {idx, 3'b000};
        nx_addr   = a_addr + {30'd0, idx};
        nx_funct3 = a_split ? (a_write ? F3_B : F3_BU) : a_funct3;
        nx_wdata  = a_split ? (a_write ? {24'd0, wshift[7:0]} : 32'd0) : a_wdata;
    end

    logic [31:0] raw_split;
    logic [31:0] raw_sel;
    logic [31:0] ext_data;
    logic        last_byte;

    always_comb begin
        raw_split = buf_q;
        raw_split[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
    end

    assign raw_sel   = split_q ? raw_split : mem_rdata;
    assign last_byte = !split_q || ({1'b0, k_q} == (n_q - 3'd1));

    load_extender u_ext (
        .funct3 (funct3_q),
        .raw    (raw_sel),
        .ext    (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            funct3_q   <= 3'd0;
            write_q    <= 1'b0;
            split_q    <= 1'b0;
            n_q        <= 3'd0;
            k_q        <= 2'd0;
            buf_q      <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_funct3 <= 3'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_funct3 <= 3'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        write_q  <= req_write;
                        split_q  <= req_split;
                        n_q      <= req_size;
                        k_q      <= 2'd0;
                        buf_q    <= 32'd0;
                        if (req_fault) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            state      <= ST_ACCESS;
                            mem_addr   <= nx_addr;
                            mem_wdata  <= nx_wdata;
                            mem_funct3 <= nx_funct3;
                            mem_read   <= !req_write;
                            mem_write  <= req_write;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!write_q) begin
                        state <= ST_CAPTURE;
                    end else if (last_byte) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        k_q        <= k_q + 2'd1;
                        mem_addr   <= nx_addr;
                        mem_wdata  <= nx_wdata;
                        mem_funct3 <= nx_funct3;
                        mem_write  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    buf_q <= raw_sel;
                    if (last_byte) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ext_data;
                    end else begin
                        state      <= ST_ACCESS;
                        k_q        <= k_q + 2'd1;
                        mem_addr   <= nx_addr;
                        mem_wdata  <= nx_wdata;
                        mem_funct3 <= nx_funct3;
                        mem_read   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-array reference
module tb_load_store_unit;

    localparam int MEMB = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid0;
    logic        req_ready, req_ready0;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_fault, resp_valid0, resp_fault0;
    logic [31:0] resp_rdata, resp_rdata0;
    logic [31:0] mem_addr, mem_wdata, mem_addr0, mem_wdata0;
    logic [2:0]  mem_funct3, mem_funct30;
    logic        mem_read, mem_write, mem_read0, mem_write0;
    logic [31:0] mem_rdata;
    logic [31:0] mem_rdata0 = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEMB), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MEM_BYTES(MEMB), .SPLIT_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_fault(resp_fault0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_funct3(mem_funct30),
        .mem_read(mem_read0), .mem_write(mem_write0), .mem_rdata(mem_rdata0)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference helpers: plain arithmetic on byte counts and values.
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        if (f3 == 3'd2) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input longint unsigned v);
        int n;
        longint s;
        n = size_of(f3);
        if (n == 0) return 32'd0;
        s = longint'(v % (64'd1 << (8 * n)));
        if ((f3 == 3'd0 || f3 == 3'd1) && s >= (64'sd1 << (8 * n - 1))) s = s - (64'sd1 << (8 * n));
        return 32'(s);
    endfunction

    function automatic logic ref_fault(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic split);
        int n;
        logic mis;
        n = size_of(f3);
        if (n == 0 || (w && n < 4 && f3 >= 3'd4)) return 1'b1;
        if (longint'(a) + longint'(n) > longint'(MEMB)) return 1'b1;
        mis = (a % n) != 0;
        return mis && !split;
    endfunction

    logic [7:0] mem     [MEMB];
    logic [7:0] ref_mem [MEMB];

    // Data memory: registered read, returns data already extended for its access size.
    always @(posedge clk) begin
        if (mem_write)
            for (int i = 0; i < size_of(mem_funct3); i++)
                mem[(mem_addr + i) % MEMB] = mem_wdata[8*i +: 8];
        if (mem_read) begin
            longint unsigned v;
            v = 0;
            for (int i = 0; i < size_of(mem_funct3); i++)
                v = v + (longint'(mem[(mem_addr + i) % MEMB]) << (8 * i));
            mem_rdata <= extend(mem_funct3, v);
        end
    end

    typedef struct {logic w; logic [31:0] a; logic [2:0] f3; logic [31:0] wd;} strobe_t;
    strobe_t strobes[$];
    int      strobes0 = 0;

    always @(negedge clk) begin
        if (mem_read || mem_write) strobes.push_back('{mem_write, mem_addr, mem_funct3, mem_wdata});
        if (mem_read0 || mem_write0) strobes0++;
    end

    task automatic wait_ready(input logic which0);
        int t = 0;
        @(negedge clk);
        while (!(which0 ? req_ready0 : req_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", {31'd0, which0 ? req_ready0 : req_ready}, 32'd1);
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        int n, cyc, exp_lat, exp_cnt;
        logic flt, split, got;
        logic [31:0] exp_rd;
        longint unsigned v;
        n     = size_of(f3);
        flt   = ref_fault(w, f3, a, 1'b1);
        split = !flt && (a % n) != 0;
        exp_rd = 32'd0;
        if (!flt && !w) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[(a + i) % MEMB]) << (8 * i));
            exp_rd = extend(f3, v);
        end
        exp_cnt = flt ? 0 : (split ? n : 1);
        exp_lat = flt ? 1 : (split ? (w ? n + 1 : 2 * n + 1) : (w ? 2 : 3));
        wait_ready(1'b0);
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        strobes.delete();
        @(posedge clk);
        cyc = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            got = resp_valid;
        end
        check({tag, "_lat"}, got ? cyc : 32'hFFFF_FFFF, exp_lat);
        check({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, flt});
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_nstrobe"}, strobes.size(), exp_cnt);
        for (int i = 0; i < exp_cnt && i < strobes.size(); i++) begin
            check({tag, "_saddr"}, strobes[i].a, a + (split ? i : 0));
            check({tag, "_sf3"}, {29'd0, strobes[i].f3}, {29'd0, split ? (w ? 3'd0 : 3'd4) : f3});
            check({tag, "_sw"}, {31'd0, strobes[i].w}, {31'd0, w});
            if (w) check({tag, "_swd"}, strobes[i].wd, split ? ((wd >> (8 * i)) & 32'hFF) : wd);
        end
        if (w && !flt)
            for (int i = 0; i < n; i++) ref_mem[(a + i) % MEMB] = wd[8*i +: 8];
    endtask

    task automatic do_req0(input logic w, input logic [2:0] f3, input logic [31:0] a, input string tag);
        int cyc;
        logic flt, got;
        flt = ref_fault(w, f3, a, 1'b0);
        wait_ready(1'b1);
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = 32'h1234_5678; req_valid0 = 1'b1;
        strobes0 = 0;
        @(posedge clk);
        cyc = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            req_valid0 = 1'b0;
            cyc++;
            got = resp_valid0;
        end
        check({tag, "_lat"}, got ? cyc : 32'hFFFF_FFFF, flt ? 1 : (w ? 2 : 3));
        check({tag, "_fault"}, {31'd0, resp_fault0}, {31'd0, flt});
        check({tag, "_nstrobe"}, strobes0, flt ? 0 : 1);
    endtask

    task automatic preset(input int a, input logic [7:0] b);
        mem[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic reset_mid_split;
        int t;
        logic seen, bad;
        wait_ready(1'b0);
        req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h102; req_valid = 1'b1;
        @(posedge clk);
        t = 0; seen = 1'b0;
        while (t < 20 && !seen) begin
            @(negedge clk);
            req_valid = 1'b0;
            t++;
            seen = mem_read && mem_addr == 32'h104;
        end
        check("rst_third_byte", {31'd0, seen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_strobe_drop", {30'd0, mem_read, mem_write}, 32'd0);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            bad = bad | resp_valid;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bad = bad | resp_valid;
        end
        check("rst_no_resp", {31'd0, bad}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0;
        req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        for (int i = 0; i < MEMB; i++) preset(i, 8'($urandom));
        preset(32'h100, 8'hEF); preset(32'h101, 8'hBE); preset(32'h102, 8'hAD); preset(32'h103, 8'hDE);
        preset(32'h205, 8'h80);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_resp", {30'd0, resp_valid, resp_fault}, 32'd0);
        check("reset_rdata", resp_rdata, 32'd0);
        check("reset_mem", {29'd0, mem_read, mem_write, |mem_funct3}, 32'd0);
        check("reset_maddr", mem_addr | mem_wdata, 32'd0);

        do_req(1'b0, 3'd2, 32'h100, 32'd0, "lw_100");
        do_req(1'b0, 3'd0, 32'h205, 32'd0, "lb_205");
        do_req(1'b0, 3'd4, 32'h205, 32'd0, "lbu_205");
        preset(32'h102, 8'h11); preset(32'h103, 8'h22); preset(32'h104, 8'h33); preset(32'h105, 8'h44);
        do_req(1'b0, 3'd2, 32'h102, 32'd0, "lw_split");
        do_req(1'b1, 3'd1, 32'h301, 32'h0000_ABCD, "sh_split");
        do_req(1'b0, 3'd5, 32'h301, 32'd0, "lhu_301");
        do_req(1'b0, 3'd3, 32'h100, 32'd0, "f3_3");
        do_req(1'b1, 3'd2, 32'hFFE, 32'h1111_2222, "sw_ffe");
        do_req(1'b1, 3'd4, 32'h10, 32'h1, "sbu_illegal");
        do_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, "lw_wrap");
        do_req(1'b0, 3'd0, 32'hFFF, 32'd0, "lb_last");
        do_req0(1'b0, 3'd1, 32'h001, "nosplit_lh");
        do_req0(1'b1, 3'd2, 32'h100, "nosplit_sw");

        for (int i = 0; i < 80; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0, 1: a = 32'($urandom_range(0, MEMB - 1));
                2:    a = 32'(MEMB - $urandom_range(1, 6));
                3:    a = 32'($urandom_range(MEMB, MEMB + 100));
                default: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h300 + 32'($urandom_range(0, 7));
            do_req(1'($urandom), f3, a, $urandom, "rand");
        end

        reset_mid_split();
        preset(32'h100, 8'h78); preset(32'h101, 8'h56); preset(32'h102, 8'h34); preset(32'h103, 8'h12);
        do_req(1'b0, 3'd2, 32'h100, 32'd0, "lw_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
